// File: rtl/iq_integrator_pkg.sv
// rtl/iq_integrator_pkg.sv - shared widths and FSM state type for the IQ integrator
package iq_integrator_pkg;

  localparam int NUM_LANES = 5;
  localparam int SAMPLE_W  = 16;
  localparam int ACC_W     = 32;
  localparam int LEN_W     = 11;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } state_e;

  // Headroom so a full-scale sum of all lanes cannot wrap inside the adder tree.
  function automatic int sum_width(input int sample_w, input int lanes);
    return sample_w + $clog2(lanes);
  endfunction

endpackage

// File: rtl/iq_integrator_lane_sum.sv
// rtl/iq_integrator_lane_sum.sv - combinational signed sum of all packed lanes
module lane_sum #(
  parameter int NUM_LANES = iq_integrator_pkg::NUM_LANES,
  parameter int SAMPLE_W  = iq_integrator_pkg::SAMPLE_W,
  parameter int SUM_W     = iq_integrator_pkg::sum_width(SAMPLE_W, NUM_LANES)
) (
  input  logic [NUM_LANES*SAMPLE_W-1:0] lanes_i,
  output logic signed [SUM_W-1:0]       sum_o
);
  import iq_integrator_pkg::*;

  always_comb begin
    sum_o = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      sum_o = sum_o + SUM_W'($signed(lanes_i[k*SAMPLE_W +: SAMPLE_W]));
    end
  end

endmodule

// File: rtl/iq_integrator.sv
// rtl/iq_integrator.sv - windowed I/Q integrator: sums all lanes over sample_length cycles
module iq_integrator #(
  parameter int NUM_LANES = iq_integrator_pkg::NUM_LANES,
  parameter int SAMPLE_W  = iq_integrator_pkg::SAMPLE_W,
  parameter int ACC_W     = iq_integrator_pkg::ACC_W,
  parameter int LEN_W     = iq_integrator_pkg::LEN_W
) (
  input  logic                          clk100,
  input  logic                          reset,
  input  logic                          start,
  input  logic [LEN_W-1:0]              sample_length,
  input  logic [NUM_LANES*SAMPLE_W-1:0] data_i_rot,
  input  logic [NUM_LANES*SAMPLE_W-1:0] data_q_rot,
  output logic                          iq_valid,
  output logic [ACC_W-1:0]              i_val,
  output logic [ACC_W-1:0]              q_val
);
  import iq_integrator_pkg::*;

  localparam int SUM_W = sum_width(SAMPLE_W, NUM_LANES);

  state_e                  state_q, state_d;
  logic [LEN_W-1:0]        len_q, len_d;
  logic [LEN_W-1:0]        cnt_q, cnt_d;
  logic signed [ACC_W-1:0] acc_i_q, acc_i_d;
  logic signed [ACC_W-1:0] acc_q_q, acc_q_d;
  logic signed [ACC_W-1:0] ival_q, ival_d;
  logic signed [ACC_W-1:0] qval_q, qval_d;
  logic                    valid_q, valid_d;

  logic signed [SUM_W-1:0] sum_i, sum_q;
  logic signed [ACC_W-1:0] ext_i, ext_q;

  lane_sum #(.NUM_LANES(NUM_LANES), .SAMPLE_W(SAMPLE_W), .SUM_W(SUM_W)) u_sum_i (
    .lanes_i (data_i_rot),
    .sum_o   (sum_i)
  );

  lane_sum #(.NUM_LANES(NUM_LANES), .SAMPLE_W(SAMPLE_W), .SUM_W(SUM_W)) u_sum_q (
    .lanes_i (data_q_rot),
    .sum_o   (sum_q)
  );

  assign ext_i = ACC_W'(sum_i);
  assign ext_q = ACC_W'(sum_q);

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    acc_i_d = acc_i_q;
    acc_q_d = acc_q_q;
    ival_d  = ival_q;
    qval_d  = qval_q;
    valid_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          // A zero length still samples one cycle.
          len_d   = (sample_length == '0) ? LEN_W'(1) : sample_length;
          cnt_d   = '0;
          acc_i_d = '0;
          acc_q_d = '0;
          state_d = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (cnt_q == (len_q - LEN_W'(1))) begin
          ival_d  = acc_i_q + ext_i;
          qval_d  = acc_q_q + ext_q;
          valid_d = 1'b1;
          state_d = ST_IDLE;
        end else begin
          acc_i_d = acc_i_q + ext_i;
          acc_q_d = acc_q_q + ext_q;
          cnt_d   = cnt_q + LEN_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk100) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      acc_i_q <= '0;
      acc_q_q <= '0;
      ival_q  <= '0;
      qval_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      acc_i_q <= acc_i_d;
      acc_q_q <= acc_q_d;
      ival_q  <= ival_d;
      qval_q  <= qval_d;
      valid_q <= valid_d;
    end
  end

  assign iq_valid = valid_q;
  assign i_val    = ival_q;
  assign q_val    = qval_q;

endmodule

// File: tb/tb_iq_integrator.sv
// tb/tb_iq_integrator.sv - scoreboard bench for iq_integrator with a window-level reference model
module tb_iq_integrator;
  localparam int NL = 5;
  localparam int SW = 16;
  localparam int AW = 32;
  localparam int LW = 11;

  logic             clk100 = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic [LW-1:0]    sample_length = '0;
  logic [NL*SW-1:0] data_i_rot = '0;
  logic [NL*SW-1:0] data_q_rot = '0;
  logic             iq_valid;
  logic [AW-1:0]    i_val;
  logic [AW-1:0]    q_val;

  iq_integrator dut (
    .clk100        (clk100),
    .reset         (reset),
    .start         (start),
    .sample_length (sample_length),
    .data_i_rot    (data_i_rot),
    .data_q_rot    (data_q_rot),
    .iq_valid      (iq_valid),
    .i_val         (i_val),
    .q_val         (q_val)
  );

  always #5 clk100 = ~clk100;

  int cyc = 0;
  always @(posedge clk100) cyc <= cyc + 1;

  typedef struct {
    longint i;
    longint q;
    int     at;
  } exp_t;

  exp_t sb[$];
  exp_t got;
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every result pulse must match the oldest outstanding window.
  always @(negedge clk100) begin
    if (iq_valid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got pulse expected none (cycle %0d)", cyc);
      end else begin
        got = sb.pop_front();
        check("i_val", longint'($signed(i_val)), got.i);
        check("q_val", longint'($signed(q_val)), got.q);
        check("valid_cycle", longint'(cyc), longint'(got.at));
      end
    end
  end

  task automatic drive_random();
    for (int k = 0; k < NL; k++) begin
      data_i_rot[k*SW +: SW] = SW'($urandom);
      data_q_rot[k*SW +: SW] = SW'($urandom);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk100);
      start = 1'b0;
      drive_random();
    end
  endtask

  // mode 0: full-range random, 1: constant (ci, cq), 2: ramp n*k on both, 3: small random
  task automatic window(input int len, input int mode, input int ci, input int cq,
                        input bit hold, input int new_len);
    int n_eff;
    int start_cyc;
    int iv, qv;
    longint si, sq;
    logic signed [SW-1:0] r;
    @(negedge clk100);
    start         = 1'b1;
    sample_length = LW'(len);
    start_cyc     = cyc;
    n_eff         = (len == 0) ? 1 : len;
    si = 0;
    sq = 0;
    for (int n = 0; n < n_eff; n++) begin
      @(negedge clk100);
      start = hold ? 1'b1 : 1'($urandom_range(0, 1));
      if (new_len >= 0) sample_length = LW'(new_len);
      for (int k = 0; k < NL; k++) begin
        case (mode)
          1: begin iv = ci; qv = cq; end
          2: begin iv = (n + 1) * k; qv = iv; end
          3: begin iv = $urandom_range(0, 200) - 100; qv = $urandom_range(0, 200) - 100; end
          default: begin
            r = SW'($urandom); iv = int'(r);
            r = SW'($urandom); qv = int'(r);
          end
        endcase
        data_i_rot[k*SW +: SW] = SW'(iv);
        data_q_rot[k*SW +: SW] = SW'(qv);
        si += iv;
        sq += qv;
      end
    end
    sb.push_back('{i: longint'($signed(si[31:0])), q: longint'($signed(sq[31:0])),
                   at: start_cyc + 1 + n_eff});
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    idle(3);
    check("reset_valid", longint'(iq_valid), 0);
    check("reset_i_val", longint'($signed(i_val)), 0);
    check("reset_q_val", longint'($signed(q_val)), 0);
    reset = 1'b1;
    idle(2);

    window(4, 1, 1, -1, 1'b0, -1);
    idle(3);
    window(0, 1, 7, 0, 1'b0, -1);
    idle(2);
    window(3, 2, 0, 0, 1'b0, -1);
    idle(2);
    window(10, 0, 0, 0, 1'b0, 3);
    idle(2);
    window(2000, 1, 32767, -32768, 1'b1, -1);
    window(2000, 1, 32767, -32768, 1'b1, -1);
    idle(3);

    // Abort a window with reset: no pulse, outputs cleared.
    window(7, 3, 0, 0, 1'b0, -1);
    idle(2);
    @(negedge clk100);
    start         = 1'b1;
    sample_length = LW'(100);
    repeat (50) begin
      @(negedge clk100);
      start = 1'b0;
      drive_random();
    end
    reset = 1'b0;
    @(negedge clk100);
    check("abort_valid", longint'(iq_valid), 0);
    check("abort_i_val", longint'($signed(i_val)), 0);
    check("abort_q_val", longint'($signed(q_val)), 0);
    reset = 1'b1;
    idle(110);
    check("abort_no_late_i", longint'($signed(i_val)), 0);
    window(5, 0, 0, 0, 1'b0, -1);
    idle(2);

    for (int w = 0; w < 25; w++) begin
      window($urandom_range(0, 40), ($urandom_range(0, 1) == 0) ? 0 : 3, 0, 0,
             1'($urandom_range(0, 1)),
             ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2047)) : -1);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
    end

    idle(6);
    check("scoreboard_empty", longint'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/iq_integrator.md
IQ_INTEGRATOR -- requirements
Module: iq_integrator

Interface
REQ-001 Parameter NUM_LANES, default 5: parallel samples per clock per channel.
REQ-002 Parameter SAMPLE_W, default 16: signed sample width per lane.
REQ-003 Parameter ACC_W, default 32: signed accumulator and result width.
REQ-004 Parameter LEN_W, default 11: sample_length width.
REQ-005 Clock and reset: one clock; reset is synchronous and active-low.
REQ-006 Port clk100, input, 1: 100 MHz system clock; all logic on its rising edge.
REQ-007 Port reset, input, 1: synchronous, active-low reset.
REQ-008 Port start, input, 1: level request to begin an integration window.
REQ-009 Port sample_length, input, LEN_W: window length in clock cycles.
REQ-010 Port data_i_rot, input, NUM_LANES*SAMPLE_W: rotated I samples; lane k occupies bits [k*16 +: 16], two's complement.
REQ-011 Port data_q_rot, input, NUM_LANES*SAMPLE_W: rotated Q samples, same packing as data_i_rot.
REQ-012 Port iq_valid, output, 1: one-cycle pulse marking a new result.
REQ-013 Port i_val, output, ACC_W: signed integrated I result.
REQ-014 Port q_val, output, ACC_W: signed integrated Q result.

Function
REQ-015 States: IDLE and ACCUM.
REQ-016 IDLE with start=1: latch sample_length into len_r, clear acc_i, acc_q and the cycle counter, go to ACCUM.
REQ-017 ACCUM, each cycle: acc += sign-extended sum of all NUM_LANES lanes, for I and Q independently; counter increments.
REQ-018 On the ACCUM cycle where counter == len_r-1: register i_val = acc_i + lane_sum_i and q_val = acc_q + lane_sum_q at that edge; iq_valid=1 for exactly the following cycle; return to IDLE.
REQ-019 Latency: a window of N cycles samples data on N consecutive edges beginning one edge after start is seen; iq_valid rises on the edge after the last sample.
REQ-020 start held high: a new window begins in the cycle iq_valid is high, so back-to-back windows are spaced N+1 cycles.
REQ-021 start deasserting during ACCUM has no effect; the window completes.
REQ-022 Changes to sample_length during ACCUM are ignored; only len_r is used.
REQ-023 sample_length = 0: treat as 1, i.e. a single sampled cycle.
REQ-024 All arithmetic is signed two's complement: lane sum at SAMPLE_W+3 bits, sign-extended to ACC_W, wrap-around on overflow with no saturation. No overflow occurs for in-range inputs: 2047*5*32768 < 2^31.
REQ-025 i_val and q_val hold their value until the next completion; iq_valid is 0 at all other times.

Reset
REQ-026 reset=0 at a rising edge: state=IDLE; counter, len_r, acc_i, acc_q, i_val and q_val = 0; iq_valid = 0.
REQ-027 Reset mid-window aborts the window with no iq_valid pulse; start is re-evaluated on the first edge after release.

Structure
REQ-028 Shared package iq_integrator_pkg holds NUM_LANES, SAMPLE_W, ACC_W, LEN_W and the state enum typedef.
REQ-029 One sub-module, lane_sum: a combinational signed adder of NUM_LANES lanes, instantiated once for I and once for Q.
REQ-030 The top level contains only the FSM, the counter, the accumulators and the output registers.

Verification
REQ-031 Constant lanes I=1 and Q=-1, sample_length=4, start pulsed one cycle -> one iq_valid pulse 5 cycles later; i_val=20, q_val=-20.
REQ-032 start held high, sample_length=2000, all lanes I=32767 and Q=-32768 -> iq_valid every 2001 cycles; i_val=327670000, q_val=-327680000.
REQ-033 Ramp input where lane k carries n*k at cycle n, sample_length=3 -> i_val matches a reference sum of the three sampled vectors; q_val identical.
REQ-034 sample_length=0, I lanes=7 -> iq_valid after 2 cycles; i_val=35.
REQ-035 reset=0 asserted mid-window (sample_length=100 at cycle 50) -> no iq_valid pulse; outputs read 0; a fresh window afterwards gives the correct sum.
REQ-036 sample_length changed from 10 to 3 mid-window -> that result still integrates 10 cycles.
